vdp_cmd_port: RTL
=================

VDP_CMD_PORT -- requirements
Module: vdp_cmd_port

Interface
REQ-001 SHALL have parameter VRAM_AW, default 14, meaning VRAM address width.
REQ-002 SHALL have parameter CRAM_AW, default 5, meaning CRAM address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset; the ports are listed below.
- clk  in  1  the single clock.
- rst  in  1  synchronous active-high reset.
- go  in  1  decoder access-active level, held at least 1 cycle per Z80 access.
- mode  in  1  1 = control port (0xBF), 0 = data port (0xBE).
- csw_l  in  1  write strobe, active low.
- csr_l  in  1  read strobe, active low.
- data_in  in  8  Z80 write byte.
- status_in  in  8  status register value.
- data_out  out  8  Z80 read byte.
- vram_addr  out  VRAM_AW  VRAM address.
- vram_wdata  out  8  VRAM write data.
- vram_we  out  1  VRAM write request.
- vram_re  out  1  VRAM read request.
- vram_ack  in  1  arbiter grant; the access completes on the cycle ack is high.
- vram_rdata  in  8  VRAM read data, valid on the ack cycle.
- cram_addr  out  CRAM_AW  CRAM address.
- cram_wdata  out  6  CRAM write data.
- cram_we  out  1  CRAM write pulse.
- rf_addr  out  4  register index.
- rf_data  out  8  register data.
- rf_en  out  1  register write pulse.
- ovfl  out  1  sticky flag: access dropped.

Function
REQ-004 SHALL act only on a rising edge of go, so one Z80 access equals one event regardless of how long go is held.
REQ-005 Control write with first-byte flag clear SHALL latch data_in into addr[7:0] and set the flag.
REQ-006 Control write with the flag set SHALL load code := data_in[7:6] and addr[13:8] := data_in[5:0], then clear the flag.
REQ-007 On second byte with code 0, the block SHALL enter RD_PF the next cycle (VRAM prefetch).
REQ-008 On second byte with code 2, the block SHALL assert rf_en for one cycle, the next cycle, with rf_addr = data_in[3:0] and rf_data = latched low byte.
REQ-009 The block SHALL NOT assert rf_en if the register index exceeds 10.
REQ-010 Control read SHALL drive data_out = status_in and clear the first-byte flag.
REQ-011 Any data-port access SHALL clear the first-byte flag.
REQ-012 Data write with code 0, 1 or 2 SHALL enter WR_V.
REQ-013 In WR_V, vram_we SHALL be high with vram_addr = addr and vram_wdata = the byte, held until vram_ack; on the ack cycle, addr increments and the block returns to IDLE.
REQ-014 Data write with code 3 SHALL pulse cram_we for one cycle, the next cycle, with cram_addr = addr[4:0] and cram_wdata = data_in[5:0], and SHALL increment addr in the same cycle, with no FSM wait.
REQ-015 Data read SHALL drive data_out = read buffer, then enter RD_PF.
REQ-016 In RD_PF, vram_re SHALL be held until ack; on the ack cycle, read buffer := vram_rdata and addr increments.
REQ-017 FSM states SHALL be IDLE, WR_V and RD_PF only.
REQ-018 WR_V and RD_PF SHALL exit only on vram_ack.
REQ-019 vram_we and vram_re SHALL never be high together.
REQ-020 Address increment SHALL wrap modulo 2^VRAM_AW (0x3FFF -> 0x0000).
REQ-021 A data access arriving while not IDLE SHALL be dropped and SHALL set ovfl; control accesses are always accepted.
REQ-022 When vram_ack arrives in the same cycle as a new go edge, the block SHALL complete the current access first and treat the new event as arriving in IDLE, not dropped.
REQ-023 data_out SHALL hold its last value when no read is active.

Reset
REQ-024 On rst, the block SHALL clear state to IDLE, addr, code, the first-byte flag, the read buffer, data_out and ovfl to 0.
REQ-025 On rst, vram_we, vram_re, cram_we and rf_en SHALL be 0 from the next edge.
REQ-026 On rst, the go edge detector SHALL be cleared.
REQ-027 Reset mid-access SHALL abort the access with no increment, and the block SHALL ignore a vram_ack arriving after reset.

Structure
REQ-028 The state enum, the code encodings (VRAM_RD=0, VRAM_WR=1, REG_WR=2, CRAM_WR=3) and the port addresses 0xBE/0xBF SHALL live in the shared package vdp_pkg.
REQ-029 The block SHALL use one sub-module, vdp_addr_ctr (loadable, wrapping address counter with increment enable).

Verification
REQ-030 Bench SHALL cover: control 0x00 then 0x40, data write 0xAA, ack after 3 cycles -> vram_we high 3 cycles at addr 0x0000 with data 0xAA; addr becomes 0x0001.
REQ-031 Bench SHALL cover: control 0x05 then 0x82 -> a single rf_en pulse, rf_addr 2, rf_data 0x05; with second byte 0x8B instead -> no rf_en.
REQ-032 Bench SHALL cover: control 0x1F then 0xC0, data write 0x3F, then 0x15 -> cram_we pulses at cram_addr 0x1F then 0x00.
REQ-033 Bench SHALL cover: addr 0x3FFF, code 0, ack immediate -> buffer loaded from 0x3FFF, addr 0x0000; data read returns that byte and prefetches from 0x0000.
REQ-034 Bench SHALL cover: a first control byte, then a status read, then control 0x34, 0x40 -> addr low 0x34, confirming the flag was cleared.
REQ-035 Bench SHALL cover: a data write while WR_V is unacked -> write dropped and ovfl = 1; rst mid-WR_V -> vram_we 0 the next cycle and addr unchanged at 0.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP Z80 command port: FSM states, command codes
// and the Z80 I/O port addresses of the data and control ports.
package vdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_V  = 2'd1,
    ST_RD_PF = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CODE_VRAM_RD = 2'd0,
    CODE_VRAM_WR = 2'd1,
    CODE_REG_WR  = 2'd2,
    CODE_CRAM_WR = 2'd3
  } code_t;

  localparam logic [7:0] PORT_DATA = 8'hBE;
  localparam logic [7:0] PORT_CTRL = 8'hBF;

  // Highest register index that the register file implements.
  localparam logic [3:0] REG_MAX = 4'd10;

endpackage

// File: rtl/vdp_addr_ctr.sv
// Loadable VRAM address counter; increments wrap modulo 2^W.
// Also exposes the incremented value so callers can look one step ahead.
module vdp_addr_ctr #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] q_inc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q_o     = cnt_q;
  assign q_inc_o = cnt_q + W'(1);

endmodule

// File: rtl/vdp_cmd_port.sv
// Z80-facing command port of the VDP: decodes control/data port accesses into
// VRAM reads/writes, CRAM writes and register-file writes.
module vdp_cmd_port
  import vdp_pkg::*;
#(
  parameter int VRAM_AW = 14,
  parameter int CRAM_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               mode,
  input  logic               csw_l,
  input  logic               csr_l,
  input  logic [7:0]         data_in,
  input  logic [7:0]         status_in,
  output logic [7:0]         data_out,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               vram_re,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [5:0]         cram_wdata,
  output logic               cram_we,
  output logic [3:0]         rf_addr,
  output logic [7:0]         rf_data,
  output logic               rf_en,
  output logic               ovfl
);

  state_t               state_q, state_d;
  code_t                code_q, code_d;
  logic                 go_q;
  logic                 flag_q, flag_d;
  logic [7:0]           rdbuf_q, rdbuf_d;
  logic [7:0]           dout_q, dout_d;
  logic                 ovfl_q, ovfl_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 cram_we_q, cram_we_d;
  logic [CRAM_AW-1:0]   cram_addr_q, cram_addr_d;
  logic [5:0]           cram_wdata_q, cram_wdata_d;
  logic                 rf_en_q, rf_en_d;
  logic [3:0]           rf_addr_q, rf_addr_d;
  logic [7:0]           rf_data_q, rf_data_d;

  logic [VRAM_AW-1:0]   addr_q, addr_inc, addr_cur, ld_val;
  logic                 ld, inc;
  logic                 go_rise, busy, done, idle_eff, wr_ev, rd_ev;

  vdp_addr_ctr #(.W(VRAM_AW)) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (ld),
    .ld_val_i (ld_val),
    .inc_i    (inc),
    .q_o      (addr_q),
    .q_inc_o  (addr_inc)
  );

  // An ack in the same cycle as a new access retires the current access first,
  // so the new access sees IDLE and the already-incremented address.
  always_comb begin
    go_rise  = go & ~go_q;
    wr_ev    = go_rise & ~csw_l;
    rd_ev    = go_rise & csw_l & ~csr_l;
    busy     = (state_q != ST_IDLE);
    done     = busy & vram_ack;
    idle_eff = ~busy | vram_ack;
    addr_cur = done ? addr_inc : addr_q;

    state_d      = done ? ST_IDLE : state_q;
    code_d       = code_q;
    flag_d       = flag_q;
    rdbuf_d      = (done && state_q == ST_RD_PF) ? vram_rdata : rdbuf_q;
    dout_d       = dout_q;
    ovfl_d       = ovfl_q;
    wdata_d      = wdata_q;
    cram_we_d    = 1'b0;
    cram_addr_d  = cram_addr_q;
    cram_wdata_d = cram_wdata_q;
    rf_en_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    ld           = 1'b0;
    ld_val       = addr_cur;
    inc          = done;

    if (mode) begin
      if (wr_ev) begin
        ld = 1'b1;
        if (!flag_q) begin
          ld_val[7:0] = data_in;
          flag_d      = 1'b1;
        end else begin
          ld_val = VRAM_AW'({data_in[5:0], addr_cur[7:0]});
          code_d = code_t'(data_in[7:6]);
          flag_d = 1'b0;
          if (code_t'(data_in[7:6]) == CODE_VRAM_RD && idle_eff) begin
            state_d = ST_RD_PF;
          end
          if (code_t'(data_in[7:6]) == CODE_REG_WR && data_in[3:0] <= REG_MAX) begin
            rf_en_d   = 1'b1;
            rf_addr_d = data_in[3:0];
            rf_data_d = addr_cur[7:0];
          end
        end
      end else if (rd_ev) begin
        dout_d = status_in;
        flag_d = 1'b0;
      end
    end else if (wr_ev || rd_ev) begin
      flag_d = 1'b0;
      if (!idle_eff) begin
        ovfl_d = 1'b1;
      end else if (wr_ev) begin
        if (code_q == CODE_CRAM_WR) begin
          cram_we_d    = 1'b1;
          cram_addr_d  = addr_cur[CRAM_AW-1:0];
          cram_wdata_d = data_in[5:0];
          ld           = 1'b1;
          ld_val       = addr_cur + VRAM_AW'(1);
        end else begin
          state_d = ST_WR_V;
          wdata_d = data_in;
        end
      end else begin
        dout_d  = rdbuf_d;
        state_d = ST_RD_PF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      code_q       <= CODE_VRAM_RD;
      go_q         <= 1'b0;
      flag_q       <= 1'b0;
      rdbuf_q      <= '0;
      dout_q       <= '0;
      ovfl_q       <= 1'b0;
      wdata_q      <= '0;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= '0;
      cram_wdata_q <= '0;
      rf_en_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      go_q         <= go;
      flag_q       <= flag_d;
      rdbuf_q      <= rdbuf_d;
      dout_q       <= dout_d;
      ovfl_q       <= ovfl_d;
      wdata_q      <= wdata_d;
      cram_we_q    <= cram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_wdata_q <= cram_wdata_d;
      rf_en_q      <= rf_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign data_out   = dout_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign vram_we    = (state_q == ST_WR_V);
  assign vram_re    = (state_q == ST_RD_PF);
  assign cram_addr  = cram_addr_q;
  assign cram_wdata = cram_wdata_q;
  assign cram_we    = cram_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign rf_en      = rf_en_q;
  assign ovfl       = ovfl_q;

endmodule
